// File: rtl/sync_fifo_reader_if.sv
// FIFO read port plus downstream valid/ready stream for sync_fifo_reader.
// master = the reader (drives fifo_rd_en and the stream); slave = FIFO/consumer side.
interface sync_fifo_reader_if #(
  parameter int DATA = 8
);
  logic            fifo_empty;
  logic [DATA-1:0] fifo_dout;
  logic            fifo_rd_en;
  logic            flush;
  logic            m_valid;
  logic [DATA-1:0] m_data;
  logic            m_ready;

  modport master (
    input  fifo_empty, fifo_dout, flush, m_ready,
    output fifo_rd_en, m_valid, m_data
  );

  modport slave (
    output fifo_empty, fifo_dout, flush, m_ready,
    input  fifo_rd_en, m_valid, m_data
  );
endinterface

// File: rtl/sync_fifo_reader.sv
// Pops a one-cycle-latency synchronous FIFO into a small skid buffer and serves a valid/ready stream.
// Optional delivered-word counter rd_cnt is present only when FIFO_RD_CNT_EN is defined.
module sync_fifo_reader #(
  parameter int DATA      = 8,
  parameter int BUF_DEPTH = 2,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  sync_fifo_reader_if.master bus
`ifdef FIFO_RD_CNT_EN
  ,
  output logic [CNT_W-1:0]   rd_cnt
`endif
);

  localparam int IDX_W = (BUF_DEPTH > 2) ? 2 : 1;
  localparam int OCC_W = $clog2(BUF_DEPTH + 1);
  localparam logic [OCC_W-1:0] OCC_FULL_V = OCC_W'(BUF_DEPTH);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(BUF_DEPTH - 1);

  generate
    if (BUF_DEPTH < 2 || BUF_DEPTH > 4) begin : g_bad_depth
      $error("BUF_DEPTH must be in 2..4");
    end
    if (CNT_W < 1) begin : g_bad_cnt
      $error("CNT_W must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {OCC_EMPTY, OCC_PART, OCC_FULL} occ_state_t;

  logic [DATA-1:0]  buf_mem [BUF_DEPTH];
  logic [IDX_W-1:0] rd_idx_reg, rd_idx_next, rd_idx_adv;
  logic [IDX_W-1:0] wr_idx_reg, wr_idx_next;
  logic [OCC_W-1:0] occ_reg, occ_next, occ_after_pop;
  logic             infl_reg;
  logic [DATA-1:0]  m_data_reg, m_data_next;
  occ_state_t       occ_state;
  logic             pop, buf_wr, credit_ok;
  logic [OCC_W:0]   used_slots, avail_slots;

  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
    return (i == IDX_LAST) ? '0 : i + IDX_W'(1);
  endfunction

  always_comb begin
    occ_state = OCC_PART;
    if (occ_reg == '0)
      occ_state = OCC_EMPTY;
    else if (occ_reg == OCC_FULL_V)
      occ_state = OCC_FULL;
  end

  assign bus.m_valid = (occ_state != OCC_EMPTY);
  assign bus.m_data  = m_data_reg;

  // A request is only issued when a slot is guaranteed for the returning word,
  // counting the word already in flight and the slot freed by this cycle's pop.
  assign bus.fifo_rd_en = !rst && !bus.fifo_empty && !bus.flush && credit_ok;

  always_comb begin
    pop           = bus.m_valid && bus.m_ready;
    buf_wr        = infl_reg && !bus.flush;
    used_slots    = {1'b0, occ_reg} + (OCC_W+1)'(infl_reg);
    avail_slots   = (OCC_W+1)'(BUF_DEPTH) + (OCC_W+1)'(pop);
    credit_ok     = (used_slots < avail_slots);
    occ_after_pop = occ_reg - OCC_W'(pop);
    rd_idx_adv    = pop ? idx_inc(rd_idx_reg) : rd_idx_reg;
    rd_idx_next   = rd_idx_adv;
    wr_idx_next   = buf_wr ? idx_inc(wr_idx_reg) : wr_idx_reg;
    occ_next      = occ_after_pop + OCC_W'(buf_wr);
    // Registered head: next head comes from the buffer, else straight from the FIFO.
    m_data_next   = m_data_reg;
    if (occ_after_pop != '0)
      m_data_next = buf_mem[rd_idx_adv];
    else if (buf_wr)
      m_data_next = bus.fifo_dout;
    if (bus.flush) begin
      occ_next    = '0;
      rd_idx_next = '0;
      wr_idx_next = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_reg    <= '0;
      infl_reg   <= 1'b0;
      rd_idx_reg <= '0;
      wr_idx_reg <= '0;
      m_data_reg <= '0;
    end else begin
      occ_reg    <= occ_next;
      infl_reg   <= bus.fifo_rd_en;
      rd_idx_reg <= rd_idx_next;
      wr_idx_reg <= wr_idx_next;
      m_data_reg <= m_data_next;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_wr)
      buf_mem[wr_idx_reg] <= bus.fifo_dout;
  end

`ifdef FIFO_RD_CNT_EN
  logic [CNT_W-1:0] rd_cnt_reg;

  // Counts every completed pop, including one in a flush cycle; only rst clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rd_cnt_reg <= '0;
    else if (pop)
      rd_cnt_reg <= rd_cnt_reg + CNT_W'(1);
  end

  assign rd_cnt = rd_cnt_reg;
`endif

endmodule

// File: tb/tb_sync_fifo_reader.sv
// Directed bench for sync_fifo_reader with a behavioural one-cycle-latency FIFO model.
module tb_sync_fifo_reader;
  localparam int DATA      = 8;
  localparam int BUF_DEPTH = 2;
  localparam int CNT_W     = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sync_fifo_reader_if #(.DATA(DATA)) bus ();
`ifdef FIFO_RD_CNT_EN
  logic [CNT_W-1:0] rd_cnt;
`endif

  sync_fifo_reader #(.DATA(DATA), .BUF_DEPTH(BUF_DEPTH), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus)
`ifdef FIFO_RD_CNT_EN
    ,
    .rd_cnt (rd_cnt)
`endif
  );

  // FIFO model: registered dout, reads ignored when empty, pointers reset by rst.
  logic [7:0] fifo_mem [32];
  logic [4:0] wr_ptr = 5'd0;
  logic [4:0] rd_ptr;
  logic [7:0] fifo_q;

  assign bus.fifo_empty = (rd_ptr == wr_ptr);
  assign bus.fifo_dout  = fifo_q;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= 5'd0;
      fifo_q <= 8'h00;
    end else if (bus.fifo_rd_en && (rd_ptr != wr_ptr)) begin
      fifo_q <= fifo_mem[rd_ptr];
      rd_ptr <= rd_ptr + 5'd1;
    end
  end

  always @(posedge clk) begin
    if (!rst && bus.m_valid && bus.m_ready)
      $display("xfer data=%02h", bus.m_data);
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    fifo_mem[wr_ptr] = d;
    wr_ptr = wr_ptr + 5'd1;
  endtask

  logic [6:0]  s2_rd, s2_v;
  logic [10:0] s3_rd, s3_v;
  logic [9:0]  s4_rd, s4_v;
  logic [6:0]  s5_rd, s5_v;
  logic [7:0]  exp_word;
  int          got;

  initial begin
    s2_rd = 7'b0001111;  s2_v = 7'b0111100;
    s3_rd = 11'b00011100011; s3_v = 11'b01111111100;
    s4_rd = 10'b0001000011;  s4_v = 10'b0100001100;
    s5_rd = 7'b0001011;  s5_v = 7'b0100100;

    // Reset with the FIFO non-empty
    rst = 1'b1;
    bus.flush   = 1'b0;
    bus.m_ready = 1'b1;
    push(8'hA0); push(8'hA1); push(8'hA2);
    @(negedge clk); #1;
    check("rst_rd_en", bus.fifo_rd_en, 1'b0);
    check("rst_valid", bus.m_valid, 1'b0);
    check("rst_data", bus.m_data, 8'h00);
`ifdef FIFO_RD_CNT_EN
    check("rst_cnt", rd_cnt, 4'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    wr_ptr = 5'd0;
    #1;
    check("idle_rd_en", bus.fifo_rd_en, 1'b0);
    check("idle_valid", bus.m_valid, 1'b0);

    // Streaming: 10..13 with m_ready=1
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i == 0) for (int k = 0; k < 4; k++) push(8'(8'h10 + k));
      #1;
      check("s2_rd_en", bus.fifo_rd_en, s2_rd[i]);
      check("s2_valid", bus.m_valid, s2_v[i]);
      if (s2_v[i]) check("s2_data", bus.m_data, 8'h10 + i - 2);
    end

    // Backpressure: 10..14, m_ready low for 5 cycles then high
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus.m_ready = 1'b0;
        for (int k = 0; k < 5; k++) push(8'(8'h10 + k));
      end
      if (i == 5) bus.m_ready = 1'b1;
      #1;
      check("s3_rd_en", bus.fifo_rd_en, s3_rd[i]);
      check("s3_valid", bus.m_valid, s3_v[i]);
      if (s3_v[i]) check("s3_data", bus.m_data, (i <= 5) ? 8'h10 : 8'h10 + i - 5);
    end

    // Underflow: 30,31 drain, then refill with 20
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) begin push(8'h30); push(8'h31); end
      if (i == 6) push(8'h20);
      #1;
      check("s4_rd_en", bus.fifo_rd_en, s4_rd[i]);
      check("s4_valid", bus.m_valid, s4_v[i]);
      if (s4_v[i]) check("s4_data", bus.m_data, (i == 2) ? 8'h30 : (i == 3) ? 8'h31 : 8'h20);
    end

    // Flush with one word buffered and one in flight: 41 must never appear
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus.m_ready = 1'b0;
        push(8'h40); push(8'h41); push(8'h42);
      end
      bus.flush = (i == 2);
      if (i == 5) bus.m_ready = 1'b1;
      #1;
      check("s5_rd_en", bus.fifo_rd_en, s5_rd[i]);
      check("s5_valid", bus.m_valid, s5_v[i]);
      if (s5_v[i]) check("s5_data", bus.m_data, (i == 2) ? 8'h40 : 8'h42);
    end

`ifdef FIFO_RD_CNT_EN
    check("cnt_13", rd_cnt, 4'd13);
`endif
    @(negedge clk);
    rst = 1'b1;
    wr_ptr = 5'd0;
    #1;
    check("rst2_valid", bus.m_valid, 1'b0);
`ifdef FIFO_RD_CNT_EN
    check("rst2_cnt", rd_cnt, 4'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Long stream of 17 words 50..60, refilled while running
    exp_word = 8'h50;
    got = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (i == 0) for (int k = 0; k < 16; k++) push(8'(8'h50 + k));
      if (i == 8) push(8'h60);
      #1;
      check("s6_valid", bus.m_valid, (i >= 2 && i <= 18));
      if (bus.m_valid) begin
        check("s6_data", bus.m_data, exp_word);
        exp_word = exp_word + 8'd1;
        got++;
      end
    end
    check("s6_count", got, 17);
`ifdef FIFO_RD_CNT_EN
    check("cnt_wrap", rd_cnt, 4'd1);
`endif

    // Asynchronous reset in the middle of a stream
    @(negedge clk);
    push(8'h70); push(8'h71); push(8'h72);
    #1;
    check("s7_rd_en", bus.fifo_rd_en, 1'b1);
    @(negedge clk);
    @(negedge clk); #1;
    check("s7_valid_pre", bus.m_valid, 1'b1);
    check("s7_data_pre", bus.m_data, 8'h70);
    rst = 1'b1;
    #1;
    check("s7_valid_rst", bus.m_valid, 1'b0);
    check("s7_data_rst", bus.m_data, 8'h00);
    check("s7_rd_en_rst", bus.fifo_rd_en, 1'b0);
`ifdef FIFO_RD_CNT_EN
    check("s7_cnt_rst", rd_cnt, 4'd0);
`endif
    wr_ptr = 5'd0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("s7_valid_post", bus.m_valid, 1'b0);
    check("s7_rd_en_post", bus.fifo_rd_en, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
